// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator, one MSB-first word per chip-select.
// sck_o, cs_o and sdo_o come straight from flops; no input reaches a pin
// combinationally.
// Optional build macro SPI_LOOPBACK_EN adds loopback_i, which makes the
// receive shifter sample the outgoing MOSI bit instead of sdi_i.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | cs high, waiting for start_i
// S_SETUP | cs low, sck low, first MOSI bit settling
// S_SHIFT | sck toggling every CLK_DIV cycles, DATA_BITS pulses
// S_HOLD  | cs low, sck low after the last falling edge
// S_GAP   | cs high, busy still asserted to give minimum deselect time
module spi_controller #(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_tx_i,
    output logic [DATA_BITS-1:0] data_rx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sck_o,
    output logic                 cs_o,
    output logic                 sdo_o,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback_i,
`endif
    input  logic                 sdi_i
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LOAD = BW'(DATA_BITS);
    localparam logic [BW-1:0] BITS_LAST = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bits;
    logic [DATA_BITS-1:0] r_tx;
    logic [DATA_BITS-1:0] r_rx;
    logic [DATA_BITS-1:0] r_data_rx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sck;
    logic                 r_cs;
    logic                 w_miso;
    logic                 w_phase_end;
    logic [DATA_BITS-1:0] w_rx_next;

    // MOSI is the tx MSB register: cleared in reset and after the last shift.
    assign sdo_o     = r_tx[DATA_BITS-1];
    assign sck_o     = r_sck;
    assign cs_o      = r_cs;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign data_rx_o = r_data_rx;

`ifdef SPI_LOOPBACK_EN
    assign w_miso = loopback_i ? r_tx[DATA_BITS-1] : sdi_i;
`else
    assign w_miso = sdi_i;
`endif

    // Half-period down-counter reaches terminal count on the last cycle of a phase.
    assign w_phase_end = (r_cnt == '0);
    assign w_rx_next   = (r_rx << 1) | {{(DATA_BITS-1){1'b0}}, w_miso};

    // Sequencer: phase timing, shift registers and all registered pin outputs.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_data_rx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_tx    <= data_tx_i;
                        r_rx    <= '0;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_LOAD;
                        r_bits  <= BITS_LOAD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_phase_end) begin
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_phase_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_sck) begin
                            r_sck  <= 1'b0;
                            r_tx   <= r_tx << 1;
                            r_bits <= r_bits - 1'b1;
                            if (r_bits == BITS_LAST) begin
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_sck <= 1'b1;
                            r_rx  <= w_rx_next;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_cs      <= 1'b1;
                        r_data_rx <= r_rx;
                        r_done    <= 1'b1;
                        r_cnt     <= CNT_LOAD;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a CLK_DIV=2 instance with a peripheral model
// (reply presented MSB-first on cs fall, advanced on sck fall) and a
// CLK_DIV=1 instance for the fast-clock / loopback case.
module tb_spi_controller;

    localparam int D  = 8;
    localparam int CA = 2;
    localparam int CB = 1;

    logic clk_sys = 1'b0;
    logic nrst    = 1'b0;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_err   = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // instance A signals
    logic         a_start = 1'b0;
    logic [D-1:0] a_data  = '0;
    logic [D-1:0] a_rx;
    logic         a_busy, a_done, a_sck, a_cs, a_sdo, a_sdi;
    // instance B signals
    logic         b_start = 1'b0;
    logic [D-1:0] b_data  = '0;
    logic [D-1:0] b_rx;
    logic         b_busy, b_done, b_sck, b_cs, b_sdo, b_sdi;
`ifdef SPI_LOOPBACK_EN
    logic         a_loop = 1'b0;
    logic         b_loop = 1'b0;
`endif

    spi_controller #(.DATA_BITS(D), .CLK_DIV(CA)) u_dut (
        .clk_i     (clk_sys),
        .nreset_i  (nrst),
        .start_i   (a_start),
        .data_tx_i (a_data),
        .data_rx_o (a_rx),
        .busy_o    (a_busy),
        .done_o    (a_done),
        .sck_o     (a_sck),
        .cs_o      (a_cs),
        .sdo_o     (a_sdo),
`ifdef SPI_LOOPBACK_EN
        .loopback_i(a_loop),
`endif
        .sdi_i     (a_sdi)
    );

    spi_controller #(.DATA_BITS(D), .CLK_DIV(CB)) u_dut_fast (
        .clk_i     (clk_sys),
        .nreset_i  (nrst),
        .start_i   (b_start),
        .data_tx_i (b_data),
        .data_rx_o (b_rx),
        .busy_o    (b_busy),
        .done_o    (b_done),
        .sck_o     (b_sck),
        .cs_o      (b_cs),
        .sdo_o     (b_sdo),
`ifdef SPI_LOOPBACK_EN
        .loopback_i(b_loop),
`endif
        .sdi_i     (b_sdi)
    );

    // peripheral models: bit index = sck falls since cs fell
    logic [D-1:0] reply_a = '0;
    logic [D-1:0] reply_b = '0;
    int a_falls = 0, a_base = 0, a_bit;
    int b_falls = 0, b_base = 0, b_bit;
    logic b_model;

    always @(negedge a_sck) a_falls++;
    always @(negedge a_cs)  a_base = a_falls;
    always @(negedge b_sck) b_falls++;
    always @(negedge b_cs)  b_base = b_falls;

    always_comb begin
        a_bit = a_falls - a_base;
        a_sdi = (a_bit >= 0 && a_bit < D) ? reply_a[3'(D - 1 - a_bit)] : 1'b0;
        b_bit = b_falls - b_base;
        b_model = (b_bit >= 0 && b_bit < D) ? reply_b[3'(D - 1 - b_bit)] : 1'b0;
    end

`ifdef SPI_LOOPBACK_EN
    assign b_sdi = 1'b0;
`else
    assign b_sdi = b_model;
`endif

    // event recorder for instance A (sampled on the falling clock edge)
    int         ra_t[$];
    bit         ra_sdo[$];
    int         fa_t[$];
    int         csf_t[$];
    int         csr_t[$];
    bit         csr_sdo[$];
    int         bf_t[$];
    int         dn_t[$];
    logic [D-1:0] dn_rx[$];
    logic pa_sck = 1'b0, pa_cs = 1'b1, pa_busy = 1'b0;

    always @(negedge clk_sys) begin
        if (a_sck && !pa_sck) begin ra_t.push_back(cyc); ra_sdo.push_back(a_sdo); end
        if (!a_sck && pa_sck) fa_t.push_back(cyc);
        if (!a_cs && pa_cs) csf_t.push_back(cyc);
        if (a_cs && !pa_cs) begin csr_t.push_back(cyc); csr_sdo.push_back(a_sdo); end
        if (!a_busy && pa_busy) bf_t.push_back(cyc);
        if (a_done) begin dn_t.push_back(cyc); dn_rx.push_back(a_rx); end
        pa_sck  = a_sck;
        pa_cs   = a_cs;
        pa_busy = a_busy;
    end

    // event recorder for instance B
    int b_tog = 0, b_first = -1, b_last = -1, b_dn = 0;
    logic [D-1:0] b_last_rx = '0;
    logic pb_sck = 1'b0;

    always @(negedge clk_sys) begin
        if (b_sck !== pb_sck) begin
            b_tog++;
            if (b_first < 0) b_first = cyc;
            b_last = cyc;
        end
        if (b_done) begin b_dn++; b_last_rx = b_rx; end
        pb_sck = b_sck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_a();
        ra_t.delete(); ra_sdo.delete(); fa_t.delete(); csf_t.delete();
        csr_t.delete(); csr_sdo.delete(); bf_t.delete(); dn_t.delete(); dn_rx.delete();
    endtask

    task automatic start_a(input logic [D-1:0] tx);
        @(negedge clk_sys);
        a_start = 1'b1;
        a_data  = tx;
        @(negedge clk_sys);
        a_start = 1'b0;
        a_data  = D'($urandom);
    endtask

    task automatic wait_rises_a(input int n);
        int k = 0;
        while (ra_t.size() < n && k < 200) begin @(negedge clk_sys); k++; end
        check("rise_wait", (ra_t.size() >= n), 1);
    endtask

    task automatic wait_done_a(input int n);
        int k = 0;
        while (dn_t.size() < n && k < 400) begin @(negedge clk_sys); k++; end
        check("done_wait", (dn_t.size() >= n), 1);
        k = 0;
        while (a_busy && k < 50) begin @(negedge clk_sys); k++; end
        repeat (2) @(negedge clk_sys);
    endtask

    // reference: every timing offset follows from the phase length CA and word size D
    task automatic check_word_a(input int i, input logic [D-1:0] tx, input logic [D-1:0] rep);
        int t0;
        logic [D-1:0] w;
        bit ok;
        ok = (csf_t.size() > i) && (ra_t.size() >= (i + 1) * D) && (fa_t.size() >= (i + 1) * D)
             && (csr_t.size() > i) && (dn_t.size() > i) && (bf_t.size() > i);
        check("events_present", ok, 1);
        if (!ok) return;
        t0 = csf_t[i];
        w  = '0;
        for (int k = 0; k < D; k++) begin
            check("sck_rise_time", ra_t[i * D + k] - t0, (2 * k + 1) * CA);
            w = {w[D-2:0], ra_sdo[i * D + k]};
        end
        check("mosi_word", w, tx);
        check("sck_last_fall", fa_t[i * D + D - 1] - t0, 2 * D * CA);
        check("cs_low_len", csr_t[i] - t0, (2 * D + 1) * CA);
        check("sdo_after_word", csr_sdo[i], 0);
        check("done_time", dn_t[i] - t0, (2 * D + 1) * CA);
        check("rx_word", dn_rx[i], rep);
        check("busy_len", bf_t[i] - t0, (2 * D + 2) * CA);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] tx, rep, exp_b;

        // reset state
        repeat (3) @(negedge clk_sys);
        check("rst_pins_a", {a_cs, a_sck, a_sdo, a_busy, a_done}, 5'b10000);
        check("rst_rx_a", a_rx, 0);
        check("rst_pins_b", {b_cs, b_sck, b_sdo, b_busy, b_done}, 5'b10000);
        nrst = 1'b1;
        repeat (2) @(negedge clk_sys);

        // directed word, with an ignored start pulse in the middle of SHIFT
        clear_a();
        reply_a = 8'h3C;
        start_a(8'hA5);
        wait_rises_a(3);
        a_start = 1'b1;
        a_data  = 8'hFF;
        @(negedge clk_sys);
        a_start = 1'b0;
        wait_done_a(1);
        repeat (10) @(negedge clk_sys);
        check("ignored_start_cs", csf_t.size(), 1);
        check("ignored_start_done", dn_t.size(), 1);
        check_word_a(0, 8'hA5, 8'h3C);

        // randomized words
        for (int n = 0; n < 6; n++) begin
            tx  = D'($urandom);
            rep = D'($urandom);
            clear_a();
            reply_a = rep;
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            start_a(tx);
            wait_done_a(1);
            check_word_a(0, tx, rep);
        end

        // start held high: back-to-back words
        clear_a();
        rep = D'($urandom);
        reply_a = rep;
        @(negedge clk_sys);
        a_start = 1'b1;
        a_data  = 8'h01;
        @(negedge clk_sys);
        a_data  = 8'h80;
        begin
            int k = 0;
            while (csf_t.size() < 2 && k < 200) begin @(negedge clk_sys); k++; end
        end
        a_start = 1'b0;
        wait_done_a(2);
        check("b2b_words", csf_t.size(), 2);
        if (csf_t.size() == 2 && csr_t.size() >= 1 && dn_t.size() == 2) begin
            check("b2b_cs_high", csf_t[1] - csr_t[0], CA + 1);
            check("b2b_done_gap", dn_t[1] - dn_t[0], (2 * D + 2) * CA + 1);
            check_word_a(0, 8'h01, rep);
            check_word_a(1, 8'h80, rep);
        end

        // asynchronous reset after the third rising sck edge
        clear_a();
        reply_a = D'($urandom);
        start_a(D'($urandom));
        wait_rises_a(3);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_pins", {a_cs, a_sck, a_sdo, a_busy, a_done}, 5'b10000);
        check("async_rst_rx", a_rx, 0);
        repeat (3) @(negedge clk_sys);
        nrst = 1'b1;
        repeat (60) @(negedge clk_sys);
        check("no_done_after_rst", dn_t.size(), 0);
        clear_a();
        reply_a = 8'h81;
        start_a(8'hFF);
        wait_done_a(1);
        check_word_a(0, 8'hFF, 8'h81);

        // fast instance, sck toggling every cycle
        reply_b = D'($urandom);
`ifdef SPI_LOOPBACK_EN
        b_loop = 1'b1;
        exp_b  = 8'h5A;
`else
        exp_b  = reply_b;
`endif
        b_tog = 0; b_first = -1; b_last = -1; b_dn = 0;
        @(negedge clk_sys);
        b_start = 1'b1;
        b_data  = 8'h5A;
        @(negedge clk_sys);
        b_start = 1'b0;
        b_data  = D'($urandom);
        begin
            int k = 0;
            while (b_dn < 1 && k < 200) begin @(negedge clk_sys); k++; end
        end
        repeat (4) @(negedge clk_sys);
        check("fast_done", b_dn, 1);
        check("fast_toggles", b_tog, 2 * D);
        check("fast_toggle_span", b_last - b_first, 2 * D - 1);
        check("fast_rx", b_last_rx, exp_b);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
